// File: rtl/lane_shiftreg.sv
// Multi-lane serial shift register with parallel load, runtime direction, frame counter
// and a valid/ack frame holding register. Optional per-lane frame parity: LANE_SHIFTREG_PARITY_EN.
module lane_shiftreg #(
    parameter int WIDTH     = 9,
    parameter int LANES     = 1,
    parameter int FRAME_LEN = 9
) (
    input  logic                               clk,
    input  logic                               clr,
    input  logic                               en,
    input  logic                               load,
    input  logic                               dir,
    input  logic [LANES-1:0]                   sin,
    input  logic [LANES*WIDTH-1:0]             pin,
    output logic [LANES*WIDTH-1:0]             pout,
    output logic [LANES-1:0]                   sout,
    output logic [$clog2(FRAME_LEN+1)-1:0]     count,
    output logic                               done,
    output logic [LANES*WIDTH-1:0]             frame,
    output logic                               frame_vld,
    input  logic                               frame_ack,
    output logic                               ovr,
    output logic [LANES-1:0]                   frame_par
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    logic [LANES*WIDTH-1:0] sreg_r, sreg_n, shift_s, frame_r, frame_n;
    logic [CW-1:0]          count_r, count_n;
    logic                   done_r, done_n, vld_r, vld_n, ovr_r, ovr_n;
    logic [LANES-1:0]       sout_s;
    logic                   last_s, complete_s;

    assign last_s     = (count_r == CW'(FRAME_LEN - 1));
    assign complete_s = en & ~load & last_s;

    // Per-lane shifted value and the bit about to leave, both following the current dir
    always_comb begin
        shift_s = '0;
        sout_s  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (dir) begin
                shift_s[i*WIDTH +: WIDTH] = {sreg_r[i*WIDTH +: WIDTH-1], sin[i]};
                sout_s[i]                 = sreg_r[i*WIDTH + WIDTH - 1];
            end else begin
                shift_s[i*WIDTH +: WIDTH] = {sin[i], sreg_r[i*WIDTH + 1 +: WIDTH-1]};
                sout_s[i]                 = sreg_r[i*WIDTH];
            end
        end
    end

    // Next-state: load beats shift; frame capture and handshake on completion
    always_comb begin
        sreg_n  = sreg_r;
        count_n = count_r;
        done_n  = 1'b0;
        frame_n = frame_r;
        vld_n   = vld_r;
        ovr_n   = ovr_r;
        if (load) begin
            sreg_n  = pin;
            count_n = '0;
        end else if (en) begin
            sreg_n = shift_s;
            if (last_s) begin
                count_n = '0;
            end else begin
                count_n = count_r + CW'(1);
            end
        end else begin
            sreg_n  = sreg_r;
            count_n = count_r;
        end
        if (complete_s) begin
            frame_n = shift_s;
            vld_n   = 1'b1;
            done_n  = 1'b1;
            // Unconsumed frame being replaced is an overrun; a same-cycle ack is not
            if (vld_r && !frame_ack) begin
                ovr_n = 1'b1;
            end else begin
                ovr_n = ovr_r;
            end
        end else if (frame_ack && vld_r) begin
            vld_n = 1'b0;
        end else begin
            vld_n = vld_r;
        end
    end

    // State registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            sreg_r  <= '0;
            count_r <= '0;
            done_r  <= 1'b0;
            frame_r <= '0;
            vld_r   <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            sreg_r  <= sreg_n;
            count_r <= count_n;
            done_r  <= done_n;
            frame_r <= frame_n;
            vld_r   <= vld_n;
            ovr_r   <= ovr_n;
        end
    end

    assign pout      = sreg_r;
    assign sout      = sout_s;
    assign count     = count_r;
    assign done      = done_r;
    assign frame     = frame_r;
    assign frame_vld = vld_r;
    assign ovr       = ovr_r;

`ifdef LANE_SHIFTREG_PARITY_EN
    function automatic logic lane_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic [LANES-1:0] par_r, par_n;

    // Parity follows the captured frame, computed from the same post-shift value
    always_comb begin
        par_n = par_r;
        if (complete_s) begin
            for (int i = 0; i < LANES; i++) begin
                par_n[i] = lane_parity(shift_s[i*WIDTH +: WIDTH]);
            end
        end else begin
            par_n = par_r;
        end
    end

    // Parity register with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            par_r <= '0;
        end else begin
            par_r <= par_n;
        end
    end

    assign frame_par = par_r;
`else
    assign frame_par = {LANES{1'b0}};
`endif

endmodule

// File: tb/tb_lane_shiftreg.sv
// Directed self-checking bench for lane_shiftreg (WIDTH=9, LANES=2, FRAME_LEN=9).
module tb_lane_shiftreg;

    logic        clk = 1'b0;
    logic        clr = 1'b0, en = 1'b0, load = 1'b0, dir = 1'b0, frame_ack = 1'b0;
    logic [1:0]  sin = 2'b00;
    logic [17:0] pin = 18'h0;
    logic [17:0] pout, frame;
    logic [1:0]  sout, frame_par;
    logic [3:0]  count;
    logic        done, frame_vld, ovr;

    int errors = 0;
    int checks = 0;

    lane_shiftreg #(.WIDTH(9), .LANES(2), .FRAME_LEN(9)) dut (
        .clk(clk), .clr(clr), .en(en), .load(load), .dir(dir), .sin(sin), .pin(pin),
        .pout(pout), .sout(sout), .count(count), .done(done), .frame(frame),
        .frame_vld(frame_vld), .frame_ack(frame_ack), .ovr(ovr), .frame_par(frame_par)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; en = 1'b0; load = 1'b0; frame_ack = 1'b0;
        step();
        clr = 1'b0;
    endtask

    // Shift one full frame: lane0 gets v0, lane1 gets v1; checks done/count each cycle
    task automatic shift_frame(input logic [8:0] v0, input logic [8:0] v1,
                               input logic d, input logic ack_last);
        for (int i = 0; i < 9; i++) begin
            en  = 1'b1;
            dir = d;
            sin = d ? {v1[8-i], v0[8-i]} : {v1[i], v0[i]};
            frame_ack = (ack_last && i == 8) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (done !== (i == 8)) begin
                errors++;
                $display("FAIL frame_done step %0d: got %b expected %b", i, done, (i == 8));
            end
            checks++;
            if (count !== 4'((i + 1) % 9)) begin
                errors++;
                $display("FAIL frame_count step %0d: got %0d expected %0d", i, count, (i + 1) % 9);
            end
        end
        frame_ack = 1'b0;
        checks++;
        if (pout !== {v1, v0} || frame !== {v1, v0} || frame_vld !== 1'b1) begin
            errors++;
            $display("FAIL frame_capture: pout=%h frame=%h vld=%b expected %h/%h/1",
                     pout, frame, frame_vld, {v1, v0}, {v1, v0});
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        checks++;
        if ({pout, count, done, frame, frame_vld, ovr, frame_par} !== 45'h0) begin
            errors++;
            $display("FAIL reset: pout=%h count=%0d done=%b frame=%h vld=%b ovr=%b par=%b expected all 0",
                     pout, count, done, frame, frame_vld, ovr, frame_par);
        end
    endtask

    task automatic test_shift_right();
        do_clr();
        shift_frame(9'h1A5, 9'h05A, 1'b0, 1'b0);
        en = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || frame !== {9'h05A, 9'h1A5}) begin
            errors++;
            $display("FAIL right_idle: done=%b frame=%h expected 0/%h", done, frame, {9'h05A, 9'h1A5});
        end
    endtask

    task automatic test_shift_left();
        logic [1:0] exp_par;
`ifdef LANE_SHIFTREG_PARITY_EN
        exp_par = 2'b01;
`else
        exp_par = 2'b00;
`endif
        do_clr();
        shift_frame(9'h1A5, 9'h05A, 1'b1, 1'b0);
        en = 1'b0;
        checks++;
        if (frame_par !== exp_par) begin
            errors++;
            $display("FAIL left_parity: got %b expected %b", frame_par, exp_par);
        end
    endtask

    task automatic test_load();
        logic [1:0] sout_exp [4];
        sout_exp = '{2'b10, 2'b10, 2'b00, 2'b00};
        do_clr();
        load = 1'b1; en = 1'b1; dir = 1'b0; sin = 2'b11;
        pin = {9'h003, 9'h0F0};
        step();
        load = 1'b0;
        sin  = 2'b00;
        checks++;
        if (pout !== {9'h003, 9'h0F0} || count !== 4'd0) begin
            errors++;
            $display("FAIL load_value: pout=%h count=%0d expected %h/0", pout, count, {9'h003, 9'h0F0});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sout !== sout_exp[i]) begin
                errors++;
                $display("FAIL load_sout %0d: got %b expected %b", i, sout, sout_exp[i]);
            end
            step();
        end
        en = 1'b0;
        checks++;
        if (sout !== 2'b01 || pout !== {9'h000, 9'h00F} || count !== 4'd4 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_shift: sout=%b pout=%h count=%0d done=%b expected 01/%h/4/0",
                     sout, pout, count, done, {9'h000, 9'h00F});
        end
        dir = 1'b1;
        #1;
        checks++;
        if (sout !== 2'b00) begin
            errors++;
            $display("FAIL load_sout_left: got %b expected 00", sout);
        end
        dir = 1'b0;
    endtask

    task automatic test_overrun_back_to_back();
        do_clr();
        shift_frame(9'h0AA, 9'h155, 1'b0, 1'b0);
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got %b expected 0", ovr);
        end
        shift_frame(9'h155, 9'h0AA, 1'b0, 1'b0);
        en = 1'b0;
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second: got %b expected 1", ovr);
        end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        checks++;
        if (frame_vld !== 1'b0 || ovr !== 1'b1 || frame !== {9'h0AA, 9'h155}) begin
            errors++;
            $display("FAIL ovr_ack: vld=%b ovr=%b frame=%h expected 0/1/%h",
                     frame_vld, ovr, frame, {9'h0AA, 9'h155});
        end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        step();
        checks++;
        if (ovr !== 1'b1 || frame_vld !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sticky: ovr=%b vld=%b expected 1/0", ovr, frame_vld);
        end
        do_clr();
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr: got %b expected 0", ovr);
        end
    endtask

    task automatic test_ack_same_cycle();
        do_clr();
        shift_frame(9'h0AA, 9'h155, 1'b0, 1'b0);
        shift_frame(9'h155, 9'h0AA, 1'b0, 1'b1);
        en = 1'b0;
        checks++;
        if (ovr !== 1'b0 || frame_vld !== 1'b1 || frame !== {9'h0AA, 9'h155}) begin
            errors++;
            $display("FAIL ack_same: ovr=%b vld=%b frame=%h expected 0/1/%h",
                     ovr, frame_vld, frame, {9'h0AA, 9'h155});
        end
    endtask

    task automatic test_clr_midframe();
        do_clr();
        shift_frame(9'h0AA, 9'h155, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; dir = 1'b0; sin = 2'b11;
            step();
        end
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL mid_count: got %0d expected 5", count);
        end
        do_clr();
        checks++;
        if (pout !== 18'h0 || count !== 4'd0 || done !== 1'b0 || frame !== 18'h0 || frame_vld !== 1'b0) begin
            errors++;
            $display("FAIL mid_clr: pout=%h count=%0d done=%b frame=%h vld=%b expected zeros",
                     pout, count, done, frame, frame_vld);
        end
        shift_frame(9'h1A5, 9'h0F0, 1'b0, 1'b0);
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shift_right();
        test_shift_left();
        test_load();
        test_overrun_back_to_back();
        test_ack_same_cycle();
        test_clr_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
